// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Request/result bundle for the bit-serial subtractor.
//                master drives start/a/b and observes the result; slave is
//                the subtractor itself.
//  Signals     : start  - operation request (sampled only while idle)
//                a, b   - minuend / subtractor operands, WIDTH bits
//                busy   - high while bits are being processed
//                done   - one-cycle completion pulse
//                diff   - registered a - b modulo 2^WIDTH
//                borrow - registered final borrow (a < b unsigned)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor. An accepted start captures
//                a and b; one full-subtractor stage then consumes one bit per
//                cycle, LSB first, for WIDTH cycles. The result and final
//                borrow are published on the completing edge together with a
//                one-cycle done pulse.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - serial_subtractor_if.slave (start, a, b, busy, done,
//                        diff, borrow)
//  Parameters  : WIDTH - operand width in bits (2..32)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Encoding chosen so busy is state bit 0 and done is state bit 1:
    // both outputs come straight from flip-flops with no decode logic.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic [CNT_W-1:0] r_count;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // One full-subtractor stage on the current LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 is LSB.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    // Counter holds the number of bits already processed.
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy   = r_state[0];
        bus.done   = r_state[1];
        bus.diff   = r_diff;
        bus.borrow = r_borrow;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_count  <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= 1'b0;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_res   <= w_res_next;
                    r_br    <= w_br_next;
                    r_count <= r_count + CNT_W'(1);
                    // Published result changes only on the completing edge.
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor at WIDTH=8 and
//                WIDTH=16. A cycle-level model predicts busy/done/diff/borrow
//                from plain arithmetic on the accepted operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st [2];
    logic [31:0] av [2];
    logic [31:0] bv [2];

    int n_pass  = 0;
    int n_total = 0;

    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    assign bus8.start  = st[0];
    assign bus8.a      = av[0][7:0];
    assign bus8.b      = bv[0][7:0];
    assign bus16.start = st[1];
    assign bus16.a     = av[1][15:0];
    assign bus16.b     = bv[1][15:0];

    logic        s_busy [2];
    logic        s_done [2];
    logic        s_br   [2];
    logic [31:0] s_diff [2];

    assign s_busy[0] = bus8.busy;
    assign s_done[0] = bus8.done;
    assign s_br[0]   = bus8.borrow;
    assign s_diff[0] = {24'd0, bus8.diff};
    assign s_busy[1] = bus16.busy;
    assign s_done[1] = bus16.done;
    assign s_br[1]   = bus16.borrow;
    assign s_diff[1] = {16'd0, bus16.diff};

    always #5 clk = ~clk;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic [31:0] mask(input int i);
        return (32'h1 << wid(i)) - 32'h1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model. m_ph: 0 idle, 1..W processing bit m_ph, W+1 done.
    // The result is plain modular subtraction of the accepted operands.
    // ------------------------------------------------------------------
    int          m_ph   [2];
    logic [31:0] m_pd   [2];
    logic        m_pb   [2];
    logic [31:0] m_diff [2];
    logic        m_br   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i]   <= 0;
                m_pd[i]   <= '0;
                m_pb[i]   <= 1'b0;
                m_diff[i] <= '0;
                m_br[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_ph[i] == 0) begin
                    if (st[i]) begin
                        m_ph[i] <= 1;
                        m_pd[i] <= (av[i] - bv[i]) & mask(i);
                        m_pb[i] <= (av[i] & mask(i)) < (bv[i] & mask(i));
                    end
                end else if (m_ph[i] == wid(i)) begin
                    m_ph[i]   <= wid(i) + 1;
                    m_diff[i] <= m_pd[i];
                    m_br[i]   <= m_pb[i];
                end else if (m_ph[i] == wid(i) + 1) begin
                    m_ph[i] <= 0;
                end else begin
                    m_ph[i] <= m_ph[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy_w%0d", wid(i)), s_busy[i],
                  (m_ph[i] >= 1 && m_ph[i] <= wid(i)));
            check($sformatf("done_w%0d", wid(i)), s_done[i], (m_ph[i] == wid(i) + 1));
            check($sformatf("diff_w%0d", wid(i)), s_diff[i], m_diff[i]);
            check($sformatf("borrow_w%0d", wid(i)), s_br[i], m_br[i]);
        end
    end

    // ------------------------------------------------------------------
    // Directed 8-bit operation with literal expectations.
    // ------------------------------------------------------------------
    task automatic run8(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_b,
                        input string nm, input bit mid_pulse, input bit chk_busy);
        int busy_cnt;
        int cyc;
        int pulses;
        bit got;
        @(negedge clk);
        st[0] = 1'b1; av[0] = a; bv[0] = b;
        @(negedge clk);
        st[0] = 1'b0; av[0] = $urandom; bv[0] = $urandom;
        busy_cnt = 0; cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            if (s_busy[0]) busy_cnt++;
            if (s_done[0]) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                if (mid_pulse && cyc == 3) begin
                    st[0] = 1'b1; av[0] = 32'hAA; bv[0] = 32'hFF;
                end
                if (mid_pulse && cyc == 4) st[0] = 1'b0;
            end
        end
        check({nm, "_done_seen"}, got, 1);
        if (chk_busy) check({nm, "_busy_cycles"}, busy_cnt, 8);
        check({nm, "_diff"}, s_diff[0], exp_d);
        check({nm, "_borrow"}, s_br[0], exp_b);
        check({nm, "_model_diff"}, m_diff[0], exp_d);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_done[0]) pulses++;
        end
        check({nm, "_extra_done"}, pulses, 0);
    endtask

    // ------------------------------------------------------------------
    // Random regression on one instance.
    // ------------------------------------------------------------------
    task automatic run_rand(input int i);
        logic [31:0] mk;
        logic [31:0] a;
        logic [31:0] b;
        int cyc;
        mk = mask(i);
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a = $urandom & mk;
            b = $urandom & mk;
            if (n == 0) begin a = 32'd0; b = mk; end
            if (n == 1) begin a = mk; b = 32'd0; end
            if (n == 2) b = a;
            st[i] = 1'b1; av[i] = a; bv[i] = b;
            @(negedge clk);
            st[i] = 1'b0; av[i] = $urandom; bv[i] = $urandom;
            cyc = 0;
            while (!s_done[i] && cyc < wid(i) + 5) begin
                @(negedge clk);
                cyc++;
            end
            if (s_done[i]) begin
                check($sformatf("rand_w%0d_diff", wid(i)), s_diff[i], (a - b) & mk);
                check($sformatf("rand_w%0d_borrow", wid(i)), s_br[i], (a < b));
                if (n == 0) begin
                    check($sformatf("wrap_w%0d_diff", wid(i)), s_diff[i], 32'd1);
                    check($sformatf("wrap_w%0d_borrow", wid(i)), s_br[i], 32'd1);
                end
            end else begin
                check($sformatf("rand_w%0d_timeout", wid(i)), 32'd0, 32'd1);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int last;
        int npulse;
        int pulses;

        rst_n = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;

        // Start held high during reset must not leave IDLE.
        st[0] = 1'b1; av[0] = 32'h3C; bv[0] = 32'h15;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", s_busy[0], 0);
        check("reset_done", s_done[0], 0);
        check("reset_diff", s_diff[0], 0);
        check("reset_borrow", s_br[0], 0);
        @(negedge clk);
        st[0] = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run8(32'h3C, 32'h15, 32'h27, 1'b0, "op_3c_15", 1'b0, 1'b1);
        run8(32'h10, 32'h20, 32'hF0, 1'b1, "op_10_20", 1'b0, 1'b0);
        run8(32'h00, 32'h01, 32'hFF, 1'b1, "op_00_01", 1'b0, 1'b0);
        run8(32'hFF, 32'hFF, 32'h00, 1'b0, "op_ff_ff", 1'b0, 1'b0);
        run8(32'h55, 32'h11, 32'h44, 1'b0, "op_55_11_ignore", 1'b1, 1'b0);

        // Abort 0x80 - 0x01 after four processed bits.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h80; bv[0] = 32'h01;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", s_busy[0], 0);
        check("abort_done", s_done[0], 0);
        check("abort_diff", s_diff[0], 0);
        check("abort_borrow", s_br[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_done[0]) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run8(32'h80, 32'h01, 32'h7F, 1'b0, "op_80_01", 1'b0, 1'b0);

        // Start held high: completions every WIDTH+2 cycles.
        t = 0; last = -1; npulse = 0;
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h09; bv[0] = 32'h03;
        while (npulse < 4 && t < 80) begin
            @(negedge clk);
            t++;
            if (s_done[0]) begin
                if (last >= 0) check("hold_spacing", t - last, 10);
                check("hold_diff", s_diff[0], 32'h06);
                check("hold_borrow", s_br[0], 0);
                last = t;
                npulse++;
            end
        end
        check("hold_pulses", npulse, 4);
        st[0] = 1'b0;
        repeat (14) @(negedge clk);

        fork
            run_rand(0);
            run_rand(1);
        join

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port diff, output, WIDTH bits: registered result a - b, modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit: registered final borrow, 1 iff a < b unsigned.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL load a and b into shift registers, clear the borrow flip-flop and the bit counter, and go to RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with all registers held.
REQ-014 In RUN, each cycle SHALL process one bit, LSB first, with one full-subtractor stage:
- d = a0 ^ b0 ^ br
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
REQ-015 In RUN, each cycle SHALL shift d into the MSB of an internal result shift register, shift both operand registers right by one, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles, the FSM SHALL go to DONE. On that same edge, the full result SHALL be copied to diff and br_next to borrow.
REQ-017 diff and borrow SHALL change only on the completing edge, and SHALL hold their values until the next completion or reset.
REQ-018 done SHALL be registered and high only while in DONE, so it is a one-cycle pulse. DONE SHALL always go to IDLE on the next edge.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-020 start SHALL be ignored in RUN and in DONE. Operand changes on a and b after acceptance SHALL NOT affect the result.
REQ-021 If start is held high continuously, successive operations SHALL begin every WIDTH+2 cycles.
REQ-022 Unsigned wrap-around SHALL be exact for all operand pairs, including 0 - (2^WIDTH - 1) giving diff = 1 and borrow = 1.

Reset
REQ-023 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force:
- state to IDLE
- busy, done and borrow to 0
- diff to all zeros
- internal shift registers, borrow flip-flop and counter to 0
REQ-024 Reset asserted during RUN SHALL abort the operation and produce no done pulse. The first start after rst_n rises SHALL be processed normally.
REQ-025 The block SHALL leave IDLE only on the first rising edge with rst_n=1 and start=1.

Verification
REQ-026 With WIDTH=8, start with a=0x3C, b=0x15: busy SHALL be high 8 cycles, then done pulses once with diff=0x27 and borrow=0.
REQ-027 With a=0x10, b=0x20, the result SHALL be diff=0xF0, borrow=1. With a=0x00, b=0x01, it SHALL be diff=0xFF, borrow=1. With a=0xFF, b=0xFF, it SHALL be diff=0x00, borrow=0.
REQ-028 Start with a=0x55, b=0x11; pulse start with a=0xAA, b=0xFF during RUN. The block SHALL produce a single done with diff=0x44 and borrow=0.
REQ-029 Drive rst_n low for one cycle after the 4th RUN cycle of 0x80 - 0x01. busy, done, diff and borrow SHALL go to 0 at once with no done pulse. A following start with 0x80 - 0x01 SHALL give diff=0x7F, borrow=0.
REQ-030 Hold start high with fixed operands 0x09 - 0x03. done pulses SHALL be exactly 10 cycles apart, each with diff=0x06 and borrow=0.
REQ-031 Random regression of 1,000 operand pairs at WIDTH=8 and WIDTH=16: diff and borrow SHALL match a reference model of {borrow, diff} = a - b.
